alu_iterative: RTL and testbench

Execute-stage arithmetic unit directly downstream of the ALU controller: it consumes the 4-bit `Operation` code and the two 32-bit operands, then produces the ALU result through a start/done handshake. Logic, add/sub, compare and branch-condition operations complete in one cycle. Shifts run on an iterative one-bit-per-cycle shifter, so the core avoids a full barrel shifter. The pipeline control stalls on `busy` and latches `ALUResult` on `done`.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_iterative_if.sv | 22 ++
 rtl/alu_comb.sv | 34 +++
 rtl/alu_iterative.sv | 107 ++++++++++
 tb/tb_alu_iterative.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and helpers for the iterative ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BGE = 4'b1001;
    localparam logic [3:0] OP_BNE = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b1100;
    localparam logic [3:0] OP_JAL = 4'b1101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_iterative_if.sv
// Start/done handshake and operand/result bus between the ALU controller and the iterative ALU.
interface alu_iterative_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [3:0]       Operation;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALUResult;

    modport master (
        output start, Operation, SrcA, SrcB,
        input  busy, done, ALUResult
    );

    modport slave (
        input  start, Operation, SrcA, SrcB,
        output busy, done, ALUResult
    );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU results; shift codes pass SrcA through since they only land here with shamt=0.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    // Opcode decode for all non-iterative operations.
    always_comb begin
        result = {WIDTH{1'b0}};
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL,
            OP_SRL,
            OP_SRA:  result = a;
            OP_SLT:  result = WIDTH'($signed(a) < $signed(b));
            OP_BGE:  result = WIDTH'($signed(a) >= $signed(b));
            OP_BEQ:  result = WIDTH'(a == b);
            OP_BNE:  result = WIDTH'(a != b);
            OP_JAL:  result = WIDTH'(1'b1);
            default: result = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle ops via alu_comb, shifts via a one-bit-per-cycle shift register.
module alu_iterative
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            reset,
    alu_iterative_if.slave  bus
);

    alu_state_t       state_r, state_s;
    logic [SHW-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [3:0]       op_r, op_s;
    logic [WIDTH-1:0] result_r, result_s;
    logic             done_r, busy_r;
    logic [WIDTH-1:0] comb_result_s;
    logic [SHW-1:0]   shamt_s;

    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign shamt_s = bus.SrcB[SHW-1:0];

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op     (bus.Operation),
        .a      (bus.SrcA),
        .b      (bus.SrcB),
        .result (comb_result_s)
    );

    // Next-state, counter, shift register and result selection.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        shreg_s  = shreg_r;
        op_s     = op_r;
        result_s = result_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    op_s = bus.Operation;
                    if (is_shift(bus.Operation) && (shamt_s != {SHW{1'b0}})) begin
                        shreg_s = bus.SrcA;
                        cnt_s   = shamt_s;
                        state_s = SHIFT;
                    end else begin
                        result_s = comb_result_s;
                        state_s  = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                shreg_s = shift_one(op_r, shreg_r);
                cnt_s   = cnt_r - SHW'(1);
                // Last step publishes the freshly shifted value, not the stale register.
                if (cnt_r == SHW'(1)) begin
                    result_s = shreg_s;
                    state_s  = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= {SHW{1'b0}};
            shreg_r  <= {WIDTH{1'b0}};
            op_r     <= 4'b0000;
            result_r <= {WIDTH{1'b0}};
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            shreg_r  <= shreg_s;
            op_r     <= op_s;
            result_r <= result_s;
            done_r   <= (state_s == DONE);
            busy_r   <= (state_s == SHIFT);
        end
    end

    assign bus.done      = done_r;
    assign bus.busy      = busy_r;
    assign bus.ALUResult = result_r;

endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative: driver pushes expected result/cycle, monitor checks on done.
module tb_alu_iterative;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];

    alu_iterative_if #(.WIDTH(32)) bus ();

    alu_iterative #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every done must match the oldest expectation in value and cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", bus.ALUResult, 32'hxxxxxxxx);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_result"}, bus.ALUResult, e.res);
                    chk({e.name, "_cycle"}, cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input int lat, input string name);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.Operation = op; bus.SrcA = a; bus.SrcB = b;
        q.push_back('{res: want, cyc: cyc + 1 + lat, name: name});
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input int lat, input string name);
        int nb;
        logic got;
        issue(op, a, b, want, lat, name);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.Operation = 4'b0010;
        bus.SrcA = $urandom;
        bus.SrcB = $urandom;
        nb = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
            else if (bus.busy) nb++;
        end
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_busy_cycles"}, nb, lat);
    endtask

    initial begin
        bus.start = 1'b0; bus.Operation = 4'b0000; bus.SrcA = 32'd0; bus.SrcB = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", bus.ALUResult, 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;

        run_op(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, "add_wrap");
        run_op(4'b0110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, "sub_neg");
        repeat (3) @(posedge clk);
        #1 chk("result_hold", bus.ALUResult, 32'hFFFFFFFE);

        run_op(4'b0111, 32'h80000010, 32'h00000004, 32'hF8000001, 4, "sra4");
        run_op(4'b0101, 32'h80000010, 32'h00000004, 32'h08000001, 4, "srl4");
        run_op(4'b0100, 32'h00001234, 32'h00000020, 32'h00001234, 0, "sll0");
        run_op(4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000, 31, "sll31");

        run_op(4'b1100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, "slt");
        run_op(4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, "bge");
        run_op(4'b1000, 32'h00000009, 32'h00000009, 32'h00000001, 0, "beq");
        run_op(4'b1010, 32'h00000009, 32'h00000009, 32'h00000000, 0, "bne");
        run_op(4'b1101, 32'h00000000, 32'h00000000, 32'h00000001, 0, "jal");
        run_op(4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, "illegal_f");
        run_op(4'b1011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, "illegal_b");

        // Start pulsed mid-shift must be dropped.
        issue(4'b0100, 32'h00000003, 32'h00000008, 32'h00000300, 8, "sll8_busy");
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.Operation = 4'b0010; bus.SrcA = 32'd1; bus.SrcB = 32'd1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #1 chk("sll8_queue_drained", q.size(), 32'd0);

        // Back-to-back single-cycle ops with start held.
        issue(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, "b2b_xor");
        issue(4'b0001, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 0, "b2b_or");
        issue(4'b0000, 32'hFFFF0000, 32'h12345678, 32'h12340000, 0, "b2b_and");
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("b2b_queue_drained", q.size(), 32'd0);

        // Reset mid-shift aborts without a done.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.Operation = 4'b0101; bus.SrcA = 32'hFFFFFFFF; bus.SrcB = 32'd10;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_abort_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", bus.ALUResult, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run_op(4'b0010, 32'd2, 32'd3, 32'd5, 0, "add_after_reset");

        repeat (15) @(posedge clk);
        #1 chk("final_queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
